// File: rtl/fifo_pkg.sv
// Shared sizing for the 64-in/32-out synchronous FIFO: widths, depths, thresholds
// and the pointer/occupancy-level types used by the top and the RAM.
package fifo_pkg;
  localparam int WR_DEPTH_WIDTH   = 7;
  localparam int WR_DATA_WIDTH    = 64;
  localparam int RD_DEPTH_WIDTH   = WR_DEPTH_WIDTH + 1;
  localparam int RD_DATA_WIDTH    = WR_DATA_WIDTH / 2;
  localparam int WR_DEPTH         = 1 << WR_DEPTH_WIDTH;
  localparam int ALMOST_FULL_NUM  = 126;
  localparam int ALMOST_EMPTY_NUM = 4;

  // Pointers carry one wrap bit above the address; levels need the same width
  // so that a completely full FIFO (128 entries / 256 halves) is representable.
  typedef logic [WR_DEPTH_WIDTH:0] wr_ptr_t;
  typedef logic [RD_DEPTH_WIDTH:0] rd_ptr_t;
  typedef logic [WR_DEPTH_WIDTH:0] wr_lvl_t;
  typedef logic [RD_DEPTH_WIDTH:0] rd_lvl_t;
endpackage

// File: rtl/sfifo_ram_64w_32r.sv
// Simple dual-port RAM: 128 x 64-bit write port, 32-bit registered read port.
// Read address bit 0 picks the half (low half first); read data holds when rd_en is low.
module sfifo_ram_64w_32r
  import fifo_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WR_DEPTH_WIDTH-1:0] wr_addr,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      rd_en,
  input  logic [RD_DEPTH_WIDTH-1:0] rd_addr,
  output logic [RD_DATA_WIDTH-1:0]  rd_data
);

  logic [WR_DATA_WIDTH-1:0] mem [WR_DEPTH];
  logic [WR_DATA_WIDTH-1:0] rd_entry;
  logic [RD_DATA_WIDTH-1:0] rd_data_d;
  logic [RD_DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_entry  = mem[rd_addr[RD_DEPTH_WIDTH-1:1]];
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = rd_addr[0] ? rd_entry[WR_DATA_WIDTH-1:RD_DATA_WIDTH]
                             : rd_entry[RD_DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sfifo_64i_32o_256depth.sv
// Synchronous down-sizing FIFO, 64-bit writes / 32-bit reads, 128 entries (256 halves).
// Optional SFIFO_64I_32O_OUTPUT_REG_EN adds an output register (read latency 1 -> 2).
module sfifo_64i_32o_256depth
  import fifo_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic [WR_DEPTH_WIDTH:0]  wr_water_level,
  output logic                     almost_full,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  input  logic                     rd_en,
  output logic                     rd_empty,
  output logic [RD_DEPTH_WIDTH:0]  rd_water_level,
  output logic                     almost_empty
);

  logic    wr_accept;
  logic    rd_accept;
  wr_ptr_t wr_ptr_d, wr_ptr_q;
  rd_ptr_t rd_ptr_d, rd_ptr_q;
  rd_lvl_t rd_lvl_d, rd_lvl_q;
  wr_lvl_t wr_lvl_d, wr_lvl_q;
  logic    wr_full_d, wr_full_q;
  logic    rd_empty_d, rd_empty_q;
  logic    almost_full_d, almost_full_q;
  logic    almost_empty_d, almost_empty_q;
  logic [RD_DATA_WIDTH-1:0] ram_rd_data;

  // Levels are derived from the next pointers so the registered flags already
  // account for every operation accepted in the current cycle.
  always_comb begin
    wr_accept      = wr_en & ~wr_full_q & ~rst;
    rd_accept      = rd_en & ~rd_empty_q & ~rst;
    wr_ptr_d       = wr_ptr_q + wr_ptr_t'(wr_accept);
    rd_ptr_d       = rd_ptr_q + rd_ptr_t'(rd_accept);
    rd_lvl_d       = {wr_ptr_d, 1'b0} - rd_ptr_d;
    // A half-read entry still occupies a whole 64-bit slot, hence the round-up.
    wr_lvl_d       = wr_lvl_t'((rd_lvl_d + rd_lvl_t'(1)) >> 1);
    wr_full_d      = (wr_lvl_d == wr_lvl_t'(WR_DEPTH));
    rd_empty_d     = (rd_lvl_d == '0);
    almost_full_d  = (wr_lvl_d >= wr_lvl_t'(ALMOST_FULL_NUM));
    almost_empty_d = (rd_lvl_d <= rd_lvl_t'(ALMOST_EMPTY_NUM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rd_lvl_q       <= '0;
      wr_lvl_q       <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_lvl_q       <= rd_lvl_d;
      wr_lvl_q       <= wr_lvl_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  sfifo_ram_64w_32r u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[WR_DEPTH_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr_q[RD_DEPTH_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

`ifdef SFIFO_64I_32O_OUTPUT_REG_EN
  logic [RD_DATA_WIDTH-1:0] rd_out_d, rd_out_q;

  always_comb begin
    rd_out_d = ram_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_out_q <= '0;
    end else begin
      rd_out_q <= rd_out_d;
    end
  end

  assign rd_data = rd_out_q;
`else
  assign rd_data = ram_rd_data;
`endif

  assign wr_full        = wr_full_q;
  assign wr_water_level = wr_lvl_q;
  assign almost_full    = almost_full_q;
  assign rd_empty       = rd_empty_q;
  assign rd_water_level = rd_lvl_q;
  assign almost_empty   = almost_empty_q;

endmodule
